// File: rtl/eca_pkg.sv
// eca_pkg: shared types, widths and helpers for the elementary cellular-automaton engine.
package eca_pkg;
  typedef enum logic [1:0] {IDLE, STEP, DRAIN} state_t;
  localparam int OUT_W = 16;
  localparam int IN_W = 8;
  function automatic int idx_w(input int width);
    return (width / OUT_W > 1) ? $clog2(width / OUT_W) : 1;
  endfunction
endpackage

// File: rtl/eca_step.sv
// eca_step: one combinational generation of an elementary rule over the whole row.
module eca_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] row,
  input  logic [7:0]       rule,
  input  logic             wrap,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH+1:0] ext;
  // ext[j+1] mirrors row[j]; the two guard cells hold the boundary values
  assign ext = {wrap & row[0], row, wrap & row[WIDTH-1]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign nxt[i] = rule[ext[i +: 3]];
  end
endmodule

// File: rtl/eca_engine.sv
// eca_engine: loadable WIDTH-cell elementary CA row, run for N generations, streamed out in 16-bit words.
module eca_engine import eca_pkg::*; #(
  parameter int WIDTH = 256,
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rule,
  input  logic             wrap,
  input  logic [GEN_W-1:0] gens,
  input  logic             start,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic             done
);
  localparam int NW = WIDTH / OUT_W;
  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] row_q, row_d, step_row;
  logic [7:0]       rule_q, rule_d;
  logic             wrap_q, wrap_d;
  logic [GEN_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] words [NW];

  eca_step #(.WIDTH(WIDTH)) u_step (
    .row (row_q),
    .rule(rule_q),
    .wrap(wrap_q),
    .nxt (step_row)
  );

  for (genvar k = 0; k < NW; k++) begin : g_word
    assign words[k] = row_q[WIDTH-1-OUT_W*k -: OUT_W];
  end

  assign load_ready = (state_q == IDLE) && !start;
  assign busy       = state_q != IDLE;
  assign out_valid  = state_q == DRAIN;
  assign out_data   = out_valid ? words[idx_q] : '0;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rule_d  = rule_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rule_d  = rule;
          wrap_d  = wrap;
          cnt_d   = gens;
          idx_d   = '0;
          state_d = (gens == '0) ? DRAIN : STEP;
        end else if (load_valid) begin
          row_d = {row_q[WIDTH-IN_W-1:0], load_data};
        end
      end
      STEP: begin
        row_d   = step_row;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == GEN_W'(1)) ? DRAIN : STEP;
      end
      DRAIN: begin
        if (out_ready) begin
          idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          state_d = (idx_q == LAST) ? IDLE : DRAIN;
          done_d  = idx_q == LAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      rule_q  <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rule_q  <= rule_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_eca_engine.sv
// tb_eca_engine: directed and randomized checks of eca_engine (WIDTH=32 and WIDTH=256) against a row-level model.
module tb_eca_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rule = '0;
  logic        wrap = 1'b0;
  logic [7:0]  gens = '0;
  logic        start = 1'b0, start_w = 1'b0;
  logic        load_valid = 1'b0, load_valid_w = 1'b0;
  logic [7:0]  load_data = '0;
  logic        out_ready = 1'b1;
  logic        load_ready, busy, out_valid, done;
  logic        load_ready_w, busy_w, out_valid_w, done_w;
  logic [15:0] out_data, out_data_w;
  int          checks = 0;
  int          failures = 0;
  logic [255:0] m32 = '0;
  logic [255:0] m256 = '0;

  always #5 clk = ~clk;

  eca_engine #(.WIDTH(32), .GEN_W(8)) dut (
    .clk(clk), .rst(rst), .rule(rule), .wrap(wrap), .gens(gens), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .done(done)
  );

  eca_engine #(.WIDTH(256), .GEN_W(8)) dut_w (
    .clk(clk), .rst(rst), .rule(rule), .wrap(wrap), .gens(gens), .start(start_w),
    .load_valid(load_valid_w), .load_data(load_data), .load_ready(load_ready_w),
    .busy(busy_w), .out_valid(out_valid_w), .out_data(out_data_w), .out_ready(out_ready), .done(done_w)
  );

  function automatic logic [255:0] mask_w(input int w);
    return (w == 256) ? '1 : ((256'd1 << w) - 256'd1);
  endfunction

  // One generation computed cell by cell from the rule number's binary expansion
  function automatic logic [255:0] eca_gen(input logic [255:0] r, input int w, input int rn, input bit wr);
    logic [255:0] n = '0;
    for (int i = 0; i < w; i++) begin
      int l = (i == w - 1) ? (wr ? int'(r[0]) : 0) : int'(r[i+1]);
      int c = int'(r[i]);
      int rr = (i == 0) ? (wr ? int'(r[w-1]) : 0) : int'(r[i-1]);
      n[i] = ((rn >> (4 * l + 2 * c + rr)) & 1) == 1;
    end
    return n;
  endfunction

  function automatic logic [255:0] model_run(input logic [255:0] r, input int w, input int rn, input bit wr, input int g);
    logic [255:0] x = r;
    for (int k = 0; k < g; k++) x = eca_gen(x, w, rn, wr);
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; start_w = 1'b0; load_valid = 1'b0; load_valid_w = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; m32 = '0; m256 = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 10;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (load_ready_w !== 1'b1) begin failures++; $display("FAIL reset_w_load_ready got=%b exp=1", load_ready_w); end
    if (busy_w !== 1'b0) begin failures++; $display("FAIL reset_w_busy got=%b exp=0", busy_w); end
    if (out_valid_w !== 1'b0) begin failures++; $display("FAIL reset_w_out_valid got=%b exp=0", out_valid_w); end
    if (out_data_w !== 16'h0) begin failures++; $display("FAIL reset_w_out_data got=%h exp=0000", out_data_w); end
    if (done_w !== 1'b0) begin failures++; $display("FAIL reset_w_done got=%b exp=0", done_w); end
  endtask

  task automatic load_bytes(input bit big, input logic [7:0] b[$]);
    foreach (b[i]) begin
      if (big) load_valid_w = 1'b1; else load_valid = 1'b1;
      load_data = b[i];
      #1;
      checks++;
      if ((big ? load_ready_w : load_ready) !== 1'b1) begin
        failures++; $display("FAIL load_ready byte=%0d got=%b exp=1", i, big ? load_ready_w : load_ready);
      end
      @(negedge clk);
      if (big) m256 = ((m256 << 8) | 256'(b[i])) & mask_w(256);
      else m32 = ((m32 << 8) | 256'(b[i])) & mask_w(32);
    end
    load_valid = 1'b0; load_valid_w = 1'b0;
  endtask

  // Starts a run (with a competing load byte), then drains every word, optionally stalling one word.
  task automatic run(input bit big, input logic [7:0] r, input bit wr, input logic [7:0] g,
                     input logic [255:0] exp, input int stall_at, input int stall_len, input string name);
    int w = big ? 256 : 32;
    int n = 1;
    int k = 0;
    int st = 0;
    int guard = 0;
    rule = r; wrap = wr; gens = g; load_data = 8'(($urandom));
    if (big) begin start_w = 1'b1; load_valid_w = 1'b1; end else begin start = 1'b1; load_valid = 1'b1; end
    #1;
    checks++;
    if ((big ? load_ready_w : load_ready) !== 1'b0) begin
      failures++; $display("FAIL %s ready_on_start got=%b exp=0", name, big ? load_ready_w : load_ready);
    end
    @(negedge clk);
    start = 1'b0; start_w = 1'b0; rule = ~r; wrap = ~wr; load_data = 8'($urandom);
    while (!(big ? out_valid_w : out_valid) && n < 400) begin
      start = n[0]; start_w = n[0];
      @(negedge clk); n++;
    end
    start = 1'b0; start_w = 1'b0; load_valid = 1'b0; load_valid_w = 1'b0;
    checks++;
    if (n != int'(g) + 1) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, n, int'(g) + 1); end
    while (k < w / 16 && guard < 200) begin
      logic [15:0] ew = exp[(w - 1 - 16 * k) -: 16];
      checks += 2;
      if ((big ? out_valid_w : out_valid) !== 1'b1) begin
        failures++; $display("FAIL %s out_valid word=%0d got=%b exp=1", name, k, big ? out_valid_w : out_valid);
      end
      if ((big ? out_data_w : out_data) !== ew) begin
        failures++; $display("FAIL %s word=%0d got=%h exp=%h", name, k, big ? out_data_w : out_data, ew);
      end
      if (k == stall_at && st < stall_len) begin out_ready = 1'b0; st++; end
      else begin out_ready = 1'b1; k++; end
      @(negedge clk); guard++;
    end
    out_ready = 1'b1;
    checks += 4;
    if ((big ? done_w : done) !== 1'b1) begin failures++; $display("FAIL %s done_pulse got=%b exp=1", name, big ? done_w : done); end
    if ((big ? out_valid_w : out_valid) !== 1'b0) begin failures++; $display("FAIL %s valid_after got=%b exp=0", name, big ? out_valid_w : out_valid); end
    if ((big ? busy_w : busy) !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b exp=0", name, big ? busy_w : busy); end
    @(negedge clk);
    if ((big ? done_w : done) !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", name, big ? done_w : done); end
    if (big) m256 = exp; else m32 = exp;
  endtask

  task automatic test_rule110();
    logic [7:0] q[$];
    q = '{8'h00, 8'h00, 8'h00, 8'h01};
    load_bytes(0, q);
    run(0, 8'd110, 1'b0, 8'd1, 256'h0000_0003, -1, 0, "rule110");
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    q = '{8'h80, 8'h00, 8'h00, 8'h00};
    load_bytes(0, q);
    run(0, 8'd110, 1'b1, 8'd1, 256'h8000_0001, -1, 0, "wrap1");
    load_bytes(0, q);
    run(0, 8'd110, 1'b0, 8'd1, 256'h8000_0000, -1, 0, "wrap0");
  endtask

  task automatic test_gens0();
    logic [7:0] q[$];
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_bytes(0, q);
    run(0, 8'd30, 1'b0, 8'd0, 256'hDEAD_BEEF, -1, 0, "gens0");
  endtask

  task automatic test_identity_max();
    logic [7:0] q[$];
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_bytes(0, q);
    run(0, 8'd204, 1'b1, 8'd255, 256'h1234_5678, -1, 0, "identity255");
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    logic [7:0] r;
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    load_bytes(0, q);
    r = 8'($urandom);
    run(0, r, 1'b1, 8'd3, model_run(m32, 32, int'(r), 1'b1, 3), 0, 3, "stall_w0");
    r = 8'($urandom);
    run(0, r, 1'b0, 8'd2, model_run(m32, 32, int'(r), 1'b0, 2), 1, 4, "stall_w1");
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [7:0] q[$];
      logic [7:0] r = 8'($urandom);
      bit wr = 1'($urandom);
      int g = $urandom_range(0, 12);
      int nb = $urandom_range(0, 4);
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      load_bytes(0, q);
      run(0, r, wr, 8'(g), model_run(m32, 32, int'(r), wr, g), $urandom_range(0, 2), $urandom_range(0, 3), "random32");
    end
  endtask

  task automatic test_reset_mid_step(input bit big);
    logic [7:0] q[$];
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    load_bytes(big, q);
    rule = 8'd110; wrap = 1'b0; gens = 8'd100;
    if (big) start_w = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_w = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if ((big ? busy_w : busy) !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", big ? busy_w : busy); end
    if ((big ? out_valid_w : out_valid) !== 1'b0) begin failures++; $display("FAIL rst_mid out_valid got=%b exp=0", big ? out_valid_w : out_valid); end
    if ((big ? load_ready_w : load_ready) !== 1'b1) begin failures++; $display("FAIL rst_mid load_ready got=%b exp=1", big ? load_ready_w : load_ready); end
    if ((big ? done_w : done) !== 1'b0) begin failures++; $display("FAIL rst_mid done got=%b exp=0", big ? done_w : done); end
    rst = 1'b0; m32 = '0; m256 = '0;
    run(big, 8'd90, 1'b1, 8'd0, 256'h0, -1, 0, big ? "after_rst256" : "after_rst32");
  endtask

  task automatic test_wide_random();
    logic [7:0] q[$];
    logic [7:0] r = 8'($urandom);
    for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
    load_bytes(1, q);
    run(1, r, 1'b1, 8'd5, model_run(m256, 256, int'(r), 1'b1, 5), 7, 2, "wide_random");
    r = 8'($urandom);
    run(1, r, 1'b0, 8'd3, model_run(m256, 256, int'(r), 1'b0, 3), -1, 0, "wide_continue");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rule110();
    test_wrap();
    test_gens0();
    test_identity_max();
    test_backpressure();
    test_random();
    test_reset_mid_step(1'b0);
    test_reset_mid_step(1'b1);
    test_wide_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
